alu_pipe: RTL and testbench

//  Parametrised, pipelined integer execution unit for the fcpu out-of-order core.

---
 rtl/alu_pipe.sv | 149 ++++++++++++++
 tb/tb_alu_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// alu_pipe : pipelined integer ALU with elastic valid/ready stages, flush and
//            occupancy count; results leave as {tag, result} on the CDB port.
// Rev 1.0
// ============================================================================
module alu_pipe #(
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int OP_W     = 8,
    parameter int N_STAGES = 2,
    parameter int SAVE_INC = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            i_valid,
    input  logic [TAG_W-1:0]                i_tag,
    input  logic [OP_W-1:0]                 i_op,
    input  logic [DATA_W-1:0]               i_a1,
    input  logic [DATA_W-1:0]               i_a2,
    output logic                            i_ready,
    output logic                            o_valid,
    output logic [TAG_W+DATA_W-1:0]         o_cdb,
    output logic                            o_illegal,
    input  logic                            o_ready,
    output logic [$clog2(N_STAGES+1)-1:0]   occupancy
);

    localparam int HALF  = DATA_W / 2;
    localparam int SH_W  = $clog2(DATA_W);
    localparam int OCC_W = $clog2(N_STAGES + 1);

    localparam logic [OP_W-1:0] I_ADD   = OP_W'('h00);
    localparam logic [OP_W-1:0] I_ADDI  = OP_W'('h01);
    localparam logic [OP_W-1:0] I_SUB   = OP_W'('h02);
    localparam logic [OP_W-1:0] I_SUBI  = OP_W'('h03);
    localparam logic [OP_W-1:0] I_SL    = OP_W'('h04);
    localparam logic [OP_W-1:0] I_SRL   = OP_W'('h05);
    localparam logic [OP_W-1:0] I_SRA   = OP_W'('h06);
    localparam logic [OP_W-1:0] I_SAVE  = OP_W'('h07);
    localparam logic [OP_W-1:0] I_SETI2 = OP_W'('h08);
    localparam logic [OP_W-1:0] I_SETI1 = OP_W'('h09);
    localparam logic [OP_W-1:0] I_AND   = OP_W'('h0A);
    localparam logic [OP_W-1:0] I_OR    = OP_W'('h0B);
    localparam logic [OP_W-1:0] I_XOR   = OP_W'('h0C);
    localparam logic [OP_W-1:0] I_SLT   = OP_W'('h0D);

    logic [DATA_W-1:0]   dec_result;
    logic                dec_illegal;
    logic [SH_W-1:0]     sh;

    logic [N_STAGES-1:0] valid_q;
    logic [N_STAGES-1:0] valid_d;
    logic [N_STAGES-1:0] frees;
    logic [N_STAGES-1:0] src_valid;
    logic [TAG_W-1:0]    tag_q   [N_STAGES];
    logic [DATA_W-1:0]   res_q   [N_STAGES];
    logic                ill_q   [N_STAGES];
    logic [TAG_W-1:0]    src_tag [N_STAGES];
    logic [DATA_W-1:0]   src_res [N_STAGES];
    logic                src_ill [N_STAGES];
    logic [OCC_W-1:0]    occ_d;

    always_comb begin
        sh          = i_a2[SH_W-1:0];
        dec_result  = '0;
        dec_illegal = 1'b0;
        case (i_op)
            I_ADD, I_ADDI: dec_result = i_a1 + i_a2;
            I_SUB, I_SUBI: dec_result = i_a1 - i_a2;
            I_SL:          dec_result = i_a1 << sh;
            I_SRL:         dec_result = i_a1 >> sh;
            I_SRA:         dec_result = $unsigned($signed(i_a1) >>> sh);
            I_AND:         dec_result = i_a1 & i_a2;
            I_OR:          dec_result = i_a1 | i_a2;
            I_XOR:         dec_result = i_a1 ^ i_a2;
            I_SLT:         dec_result = {{(DATA_W-1){1'b0}}, ($signed(i_a1) < $signed(i_a2))};
            I_SAVE:        dec_result = i_a1 + DATA_W'(SAVE_INC);
            I_SETI2:       dec_result = {{HALF{1'b0}}, i_a2[HALF-1:0]};
            I_SETI1:       dec_result = {i_a2[HALF-1:0], i_a1[HALF-1:0]};
            default:       dec_illegal = 1'b1;
        endcase
    end

    // Ready chain: a stage frees if it is empty or everything downstream moves.
    always_comb begin
        logic f;
        frees = '0;
        f = !valid_q[N_STAGES-1] || o_ready;
        frees[N_STAGES-1] = f;
        for (int k = N_STAGES - 2; k >= 0; k--) begin
            f = !valid_q[k] || f;
            frees[k] = f;
        end
    end

    always_comb begin
        src_valid    = '0;
        src_valid[0] = i_valid;
        src_tag[0]   = i_tag;
        src_res[0]   = dec_result;
        src_ill[0]   = dec_illegal;
        for (int k = 1; k < N_STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_tag[k]   = tag_q[k-1];
            src_res[k]   = res_q[k-1];
            src_ill[k]   = ill_q[k-1];
        end
    end

    always_comb begin
        valid_d = flush ? '0 : ((frees & src_valid) | (~frees & valid_q));
        occ_d   = '0;
        for (int k = 0; k < N_STAGES; k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            occupancy <= '0;
            for (int k = 0; k < N_STAGES; k++) begin
                tag_q[k] <= '0;
                res_q[k] <= '0;
                ill_q[k] <= 1'b0;
            end
        end else begin
            valid_q   <= valid_d;
            occupancy <= occ_d;
            // Payload only moves with a valid source, so a stalled stage holds.
            for (int k = 0; k < N_STAGES; k++) begin
                if (frees[k] && src_valid[k]) begin
                    tag_q[k] <= src_tag[k];
                    res_q[k] <= src_res[k];
                    ill_q[k] <= src_ill[k];
                end
            end
        end
    end

    assign i_ready   = frees[0];
    assign o_valid   = valid_q[N_STAGES-1];
    assign o_cdb     = {tag_q[N_STAGES-1], res_q[N_STAGES-1]};
    assign o_illegal = ill_q[N_STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// Testbench for alu_pipe: directed vectors, back-pressure, flush, async reset
// and a randomised run against a reference model.
module tb_alu_pipe;

    localparam int DW = 32;
    localparam int TW = 4;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          i_valid = 1'b0;
    logic [TW-1:0] i_tag = '0;
    logic [OW-1:0] i_op = '0;
    logic [DW-1:0] i_a1 = '0;
    logic [DW-1:0] i_a2 = '0;
    logic          i_ready;
    logic          o_valid;
    logic [TW+DW-1:0] o_cdb;
    logic          o_illegal;
    logic          o_ready = 1'b1;
    logic [1:0]    occupancy;

    int vectors = 0;
    int miscompares = 0;

    alu_pipe #(.DATA_W(DW), .TAG_W(TW), .OP_W(OW), .N_STAGES(2), .SAVE_INC(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .i_tag(i_tag),
        .i_op(i_op), .i_a1(i_a1), .i_a2(i_a2), .i_ready(i_ready), .o_valid(o_valid),
        .o_cdb(o_cdb), .o_illegal(o_illegal), .o_ready(o_ready), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW:0] ref_alu(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic ill;
        r = '0;
        ill = 1'b0;
        case (op)
            8'h00, 8'h01: r = a + b;
            8'h02, 8'h03: r = a - b;
            8'h04: r = a << b[4:0];
            8'h05: r = a >> b[4:0];
            8'h06: r = $unsigned($signed(a) >>> b[4:0]);
            8'h07: r = a + 32'd2;
            8'h08: r = {16'h0, b[15:0]};
            8'h09: r = {b[15:0], a[15:0]};
            8'h0A: r = a & b;
            8'h0B: r = a | b;
            8'h0C: r = a ^ b;
            8'h0D: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    // Issues one op with o_ready high and samples the output stage around it.
    task automatic issue_one(input logic [OW-1:0] op, input logic [TW-1:0] tag,
                             input logic [DW-1:0] a1, input logic [DW-1:0] a2,
                             output logic v1, output logic v2, output logic [TW+DW-1:0] cdb,
                             output logic ill, output logic v3);
        @(negedge clk);
        o_ready = 1'b1;
        i_valid = 1'b1; i_op = op; i_tag = tag; i_a1 = a1; i_a2 = a2;
        @(negedge clk);
        i_valid = 1'b0;
        v1 = o_valid;
        @(negedge clk);
        v2 = o_valid; cdb = o_cdb; ill = o_illegal;
        @(negedge clk);
        v3 = o_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({o_valid, o_illegal, occupancy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got valid=%0b illegal=%0b occ=%0d, want 0/0/0", o_valid, o_illegal, occupancy);
        end
        vectors++;
        if (o_cdb !== '0) begin
            miscompares++;
            $display("FAIL reset_cdb: got %h, want 0", o_cdb);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (i_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %0b, want 1", i_ready);
        end
    endtask

    task automatic test_add_latency();
        logic v1, v2, v3, ill;
        logic [TW+DW-1:0] cdb;
        issue_one(8'h00, 4'd3, 32'd5, 32'd7, v1, v2, cdb, ill, v3);
        vectors++;
        if ({v1, v2, v3} !== 3'b010) begin
            miscompares++;
            $display("FAIL add_latency: got valid seq %b, want 010", {v1, v2, v3});
        end
        vectors++;
        if (cdb !== {4'd3, 32'd12} || ill !== 1'b0) begin
            miscompares++;
            $display("FAIL add_cdb: got %h ill=%0b, want 30000000c ill=0", cdb, ill);
        end
    endtask

    task automatic test_ops();
        logic [OW-1:0] ops  [15] = '{8'h02, 8'h06, 8'h0D, 8'h0D, 8'hFF, 8'h09, 8'h08, 8'h07,
                                     8'h0A, 8'h0B, 8'h0C, 8'h04, 8'h05, 8'h03, 8'h01};
        logic [DW-1:0] a1s  [15] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h1234, 32'h0000_BEEF,
                                     32'h1234_5678, 32'h7, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_0000,
                                     32'h1, 32'h8000_0000, 32'h5, 32'hFFFF_FFFF};
        logic [DW-1:0] a2s  [15] = '{32'h1, 32'd33, 32'h1, 32'hFFFF_FFFF, 32'h5678, 32'h0000_DEAD,
                                     32'hABCD_9876, 32'h0, 32'hFF00_FF00, 32'h0F0F_0000, 32'h0F0F_0F0F,
                                     32'd31, 32'd4, 32'd7, 32'h1};
        logic [DW-1:0] exps [15] = '{32'hFFFF_FFFF, 32'hC000_0000, 32'h1, 32'h0, 32'h0, 32'hDEAD_BEEF,
                                     32'h0000_9876, 32'h9, 32'hF000_F000, 32'hFFFF_F0F0, 32'hF0F0_0F0F,
                                     32'h8000_0000, 32'h0800_0000, 32'hFFFF_FFFE, 32'h0};
        logic v1, v2, v3, ill;
        logic [TW+DW-1:0] cdb;
        for (int i = 0; i < 15; i++) begin
            issue_one(ops[i], TW'(i), a1s[i], a2s[i], v1, v2, cdb, ill, v3);
            vectors++;
            if (v2 !== 1'b1 || cdb !== {TW'(i), exps[i]} || ill !== (ops[i] == 8'hFF)) begin
                miscompares++;
                $display("FAIL op_%0d(op=%h): got valid=%0b cdb=%h ill=%0b, want cdb=%h ill=%0b",
                         i, ops[i], v2, cdb, ill, {TW'(i), exps[i]}, (ops[i] == 8'hFF));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [TW+DW-1:0] q[$];
        logic [TW+DW-1:0] held;
        logic hold_valid = 1'b0;
        logic saw_full = 1'b0;
        int issued = 0;
        int outs = 0;
        int c = 0;
        while (outs < 8 && c < 60) begin
            @(negedge clk);
            o_ready = !(c >= 3 && c <= 5);
            i_valid = (issued < 8);
            i_tag = TW'(issued); i_op = 8'h00; i_a1 = DW'(issued * 10); i_a2 = DW'(issued);
            #1;
            if (hold_valid) begin
                vectors++;
                if (o_valid !== 1'b1 || o_cdb !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold: got valid=%0b cdb=%h, want 1 %h", o_valid, o_cdb, held);
                end
            end
            if (occupancy == 2'd2 && !o_ready) begin
                saw_full = 1'b1;
                vectors++;
                if (i_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_ready: got %0b, want 0", i_ready);
                end
            end
            hold_valid = o_valid && !o_ready;
            held = o_cdb;
            if (o_valid && o_ready) begin
                vectors++;
                if (q.size() == 0 || o_cdb !== q[0]) begin
                    miscompares++;
                    $display("FAIL stream_order: got %h, want %h", o_cdb, (q.size() == 0) ? '0 : q[0]);
                end
                if (q.size() != 0) void'(q.pop_front());
                outs++;
            end
            if (i_valid && i_ready) begin
                q.push_back({TW'(issued), DW'(issued * 11)});
                issued++;
            end
            c++;
        end
        @(negedge clk);
        i_valid = 1'b0;
        vectors++;
        if (outs != 8 || !saw_full) begin
            miscompares++;
            $display("FAIL stream_count: got %0d outputs full_seen=%0b, want 8 and 1", outs, saw_full);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        o_ready = 1'b0;
        i_valid = 1'b1; i_op = 8'h00; i_tag = 4'd1; i_a1 = 32'd1; i_a2 = 32'd1;
        @(negedge clk);
        i_tag = 4'd2;
        @(negedge clk);
        vectors++;
        if (occupancy !== 2'd2) begin
            miscompares++;
            $display("FAIL flush_pre_occ: got %0d, want 2", occupancy);
        end
        flush = 1'b1; i_tag = 4'd3;
        @(negedge clk);
        flush = 1'b0; i_valid = 1'b0;
        #1;
        vectors++;
        if (o_valid !== 1'b0 || occupancy !== 2'd0 || i_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_clear: got valid=%0b occ=%0d ready=%0b, want 0 0 1", o_valid, occupancy, i_ready);
        end
        o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (o_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_emit: got valid=%0b cdb=%h, want no output", o_valid, o_cdb);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        o_ready = 1'b0;
        i_valid = 1'b1; i_op = 8'h00; i_tag = 4'd5; i_a1 = 32'd2; i_a2 = 32'd2;
        @(negedge clk);
        i_tag = 4'd6;
        @(negedge clk);
        i_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (o_valid !== 1'b0 || occupancy !== 2'd0 || o_cdb !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got valid=%0b occ=%0d cdb=%h, want 0 0 0", o_valid, occupancy, o_cdb);
        end
        @(negedge clk);
        rst = 1'b0;
        o_ready = 1'b1;
        #1;
        vectors++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_release: got ready=%0b valid=%0b, want 1 0", i_ready, o_valid);
        end
    endtask

    task automatic test_random();
        logic [OW-1:0] tbl [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                    8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hFF, 8'h3C};
        logic [TW+DW:0] q[$];
        logic [DW:0] r;
        int issued = 0;
        int c = 0;
        while ((issued < 500 || q.size() != 0) && c < 5000) begin
            @(negedge clk);
            o_ready = ($urandom_range(3) != 0);
            i_valid = (issued < 500) && ($urandom_range(3) != 0);
            i_op = tbl[$urandom_range(15)];
            i_tag = TW'($urandom);
            i_a1 = $urandom;
            i_a2 = ($urandom_range(1) != 0) ? $urandom : DW'($urandom_range(40));
            #1;
            vectors++;
            if (occupancy !== 2'(q.size())) begin
                miscompares++;
                $display("FAIL rand_occ: got %0d, want %0d", occupancy, q.size());
            end
            if (o_valid && o_ready) begin
                vectors++;
                if (q.size() == 0 || {o_cdb[DW+TW-1:DW], o_illegal, o_cdb[DW-1:0]} !== q[0]) begin
                    miscompares++;
                    $display("FAIL rand_out: got tag=%h ill=%0b res=%h, want %h",
                             o_cdb[DW+TW-1:DW], o_illegal, o_cdb[DW-1:0], (q.size() == 0) ? '0 : q[0]);
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (i_valid && i_ready) begin
                r = ref_alu(i_op, i_a1, i_a2);
                q.push_back({i_tag, r});
                issued++;
            end
            c++;
        end
        i_valid = 1'b0;
        vectors++;
        if (issued != 500 || q.size() != 0) begin
            miscompares++;
            $display("FAIL rand_timeout: issued %0d with %0d pending, want 500 and 0", issued, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_ops();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
